// File: rtl/dma_master_seq_if.sv
// Command, response and openMSP430 DMA master signals of the DMA command sequencer.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface dma_master_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [14:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic [1:0]  cmd_we;
   logic [7:0]  cmd_len;
   logic        cmd_prio;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [15:0] rsp_wait;
   logic        rsp_last;

   logic [14:0] dma_addr;
   logic [15:0] dma_din;
   logic        dma_en;
   logic [1:0]  dma_we;
   logic        dma_priority;
   logic        dma_ready;
   logic        dma_resp;
   logic [15:0] dma_dout;

   logic [15:0] trace;

   modport master (
      input  cmd_valid, cmd_addr, cmd_wdata, cmd_we, cmd_len, cmd_prio,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_err, rsp_wait, rsp_last,
      input  rsp_ready,
      output dma_addr, dma_din, dma_en, dma_we, dma_priority,
      input  dma_ready, dma_resp, dma_dout,
      output trace
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_wdata, cmd_we, cmd_len, cmd_prio,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_err, rsp_wait, rsp_last,
      output rsp_ready,
      input  dma_addr, dma_din, dma_en, dma_we, dma_priority,
      output dma_ready, dma_resp, dma_dout,
      input  trace
   );
endinterface

// File: rtl/dma_master_seq.sv
// DMA command sequencer: splits word bursts into single openMSP430 DMA beats, returns one
// response per beat with data, error and wait-state count, and records a dma_ready trace.
module dma_master_seq (
   input logic              mclk,
   input logic              reset_n,
   dma_master_seq_if.master bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StCapt = 2'd2;
   localparam logic [1:0] StRsp  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [14:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  we_q, we_d;
   logic        prio_q, prio_d;
   logic [7:0]  remaining_q, remaining_d;
   logic [15:0] wait_q, wait_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] rsp_wait_q, rsp_wait_d;
   logic [15:0] trace_q, trace_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      prio_d      = prio_q;
      remaining_d = remaining_q;
      wait_d      = wait_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_wait_d  = rsp_wait_q;
      trace_d     = {trace_q[14:0], bus.dma_ready};

      case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               addr_d      = bus.cmd_addr;
               wdata_d     = bus.cmd_wdata;
               we_d        = bus.cmd_we;
               prio_d      = bus.cmd_prio;
               remaining_d = bus.cmd_len;
               wait_d      = 16'h0000;
               state_d     = StReq;
            end
         end
         StReq: begin
            if (bus.dma_ready) begin
               rsp_wait_d = wait_q;
               state_d    = StCapt;
            end else if (wait_q != 16'hFFFF) begin
               wait_d = wait_q + 16'd1;
            end
         end
         StCapt: begin
            // Read data and error are only meaningful in the cycle after the grant.
            rsp_err_d  = bus.dma_resp;
            rsp_data_d = (we_q == 2'b00) ? bus.dma_dout : 16'h0000;
            state_d    = StRsp;
         end
         StRsp: begin
            if (bus.rsp_ready) begin
               if (rsp_err_q || (remaining_q == 8'd0)) begin
                  state_d = StIdle;
               end else begin
                  remaining_d = remaining_q - 8'd1;
                  addr_d      = addr_q + 15'd1;
                  wait_d      = 16'h0000;
                  state_d     = StReq;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= '0;
         prio_q      <= 1'b0;
         remaining_q <= '0;
         wait_q      <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_wait_q  <= '0;
         trace_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         prio_q      <= prio_d;
         remaining_q <= remaining_d;
         wait_q      <= wait_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_wait_q  <= rsp_wait_d;
         trace_q     <= trace_d;
      end
   end

   logic in_req;
   logic in_rsp;

   always_comb begin
      in_req           = (state_q == StReq);
      in_rsp           = (state_q == StRsp);
      bus.cmd_ready    = (state_q == StIdle);
      bus.dma_en       = in_req;
      bus.dma_addr     = in_req ? addr_q : 15'h0000;
      bus.dma_din      = in_req ? wdata_q : 16'h0000;
      bus.dma_we       = in_req ? we_q : 2'b00;
      bus.dma_priority = in_req & prio_q;
      bus.rsp_valid    = in_rsp;
      bus.rsp_data     = rsp_data_q;
      bus.rsp_err      = rsp_err_q;
      bus.rsp_wait     = rsp_wait_q;
      bus.rsp_last     = in_rsp & (rsp_err_q | (remaining_q == 8'd0));
      bus.trace        = trace_q;
   end

endmodule

// File: tb/tb_dma_master_seq.sv
// Directed bench for dma_master_seq: single read, wrapping write burst, wait states and
// saturation, error abort, backpressure, reset mid-command and the dma_ready trace.
module tb_dma_master_seq;

   logic mclk    = 1'b0;
   logic reset_n = 1'b0;

   always #5 mclk = ~mclk;

   dma_master_seq_if bus ();

   dma_master_seq dut (
      .mclk    (mclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled at the falling edge, between active edges.
   task automatic step();
      @(negedge mclk);
   endtask

   task automatic send_cmd(input logic [14:0] addr, input logic [15:0] wdata,
                           input logic [1:0] we, input logic [7:0] len, input logic prio);
      check_eq("cmd_ready_before_accept", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_we    = we;
      bus.cmd_len   = len;
      bus.cmd_prio  = prio;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int          bad;
      logic [14:0] exp_addr;
      logic [15:0] exp_data;
      logic [3:0]  pat;

      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_we    = '0;
      bus.cmd_len   = '0;
      bus.cmd_prio  = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.dma_ready = 1'b0;
      bus.dma_resp  = 1'b0;
      bus.dma_dout  = '0;

      // Reset state
      step();
      check_eq("rst_cmd_ready", bus.cmd_ready, 1);
      check_eq("rst_dma_en", bus.dma_en, 0);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_trace", bus.trace, 0);
      check_eq("rst_rsp_wait", bus.rsp_wait, 0);
      reset_n = 1'b1;
      step();

      // Single zero-wait read
      send_cmd(15'h0100, 16'h0000, 2'b00, 8'd0, 1'b1);
      check_eq("rd_dma_en", bus.dma_en, 1);
      check_eq("rd_dma_addr", bus.dma_addr, 15'h0100);
      check_eq("rd_dma_we", bus.dma_we, 0);
      check_eq("rd_dma_prio", bus.dma_priority, 1);
      check_eq("rd_cmd_ready_busy", bus.cmd_ready, 0);
      bus.dma_ready = 1'b1;
      step();
      bus.dma_ready = 1'b0;
      check_eq("rd_capt_dma_en", bus.dma_en, 0);
      check_eq("rd_capt_rsp_valid", bus.rsp_valid, 0);
      bus.dma_dout = 16'hBEEF;
      step();
      bus.dma_dout = 16'h0000;
      check_eq("rd_rsp_valid", bus.rsp_valid, 1);
      check_eq("rd_rsp_data", bus.rsp_data, 16'hBEEF);
      check_eq("rd_rsp_err", bus.rsp_err, 0);
      check_eq("rd_rsp_wait", bus.rsp_wait, 0);
      check_eq("rd_rsp_last", bus.rsp_last, 1);
      check_eq("rd_rsp_dma_we", bus.dma_we, 0);

      // Final handshake with a command offered in the same cycle: accepted one cycle later
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 15'h0200;
      bus.cmd_wdata = 16'h0000;
      bus.cmd_we    = 2'b00;
      bus.cmd_len   = 8'd0;
      bus.cmd_prio  = 1'b0;
      step();
      bus.rsp_ready = 1'b0;
      check_eq("sim_cmd_ready", bus.cmd_ready, 1);
      check_eq("sim_not_accepted", bus.dma_en, 0);
      check_eq("sim_rsp_valid", bus.rsp_valid, 0);
      step();
      bus.cmd_valid = 1'b0;
      check_eq("sim_dma_en", bus.dma_en, 1);
      check_eq("sim_dma_addr", bus.dma_addr, 15'h0200);
      bus.dma_ready = 1'b1;
      step();
      bus.dma_ready = 1'b0;
      step();
      check_eq("sim_rsp_valid2", bus.rsp_valid, 1);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check_eq("sim_back_idle", bus.cmd_ready, 1);

      // Write burst across the 15-bit address wrap
      bus.dma_ready = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.dma_dout  = 16'h1234;
      send_cmd(15'h7FFE, 16'hA5A5, 2'b11, 8'd3, 1'b0);
      for (int b = 0; b < 4; b++) begin
         exp_addr = 15'h7FFE + 15'(b);
         check_eq("wr_dma_en", bus.dma_en, 1);
         check_eq("wr_dma_addr", bus.dma_addr, exp_addr);
         check_eq("wr_dma_din", bus.dma_din, 16'hA5A5);
         check_eq("wr_dma_we", bus.dma_we, 2'b11);
         step();
         step();
         check_eq("wr_rsp_valid", bus.rsp_valid, 1);
         check_eq("wr_rsp_data", bus.rsp_data, 0);
         check_eq("wr_rsp_last", bus.rsp_last, (b == 3) ? 1 : 0);
         step();
      end
      check_eq("wr_back_idle", bus.cmd_ready, 1);
      bus.dma_ready = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.dma_dout  = 16'h0000;

      // Five wait states with request held stable
      send_cmd(15'h0042, 16'h1357, 2'b01, 8'd0, 1'b1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.dma_en !== 1'b1 || bus.dma_addr !== 15'h0042 || bus.dma_din !== 16'h1357 ||
             bus.dma_we !== 2'b01 || bus.dma_priority !== 1'b1)
            bad++;
         if (i == 5) bus.dma_ready = 1'b1;
         step();
      end
      bus.dma_ready = 1'b0;
      check_eq("ws_req_stable", bad, 0);
      step();
      check_eq("ws_rsp_valid", bus.rsp_valid, 1);
      check_eq("ws_rsp_wait", bus.rsp_wait, 5);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;

      // Wait counter saturation
      send_cmd(15'h0010, 16'h0000, 2'b00, 8'd0, 1'b0);
      repeat (70000) step();
      bus.dma_ready = 1'b1;
      step();
      bus.dma_ready = 1'b0;
      step();
      check_eq("sat_rsp_valid", bus.rsp_valid, 1);
      check_eq("sat_rsp_wait", bus.rsp_wait, 16'hFFFF);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;

      // Error on the third beat aborts the burst
      bus.dma_ready = 1'b1;
      bus.rsp_ready = 1'b1;
      send_cmd(15'h0400, 16'h0000, 2'b00, 8'd7, 1'b0);
      for (int b = 0; b < 3; b++) begin
         exp_addr = 15'h0400 + 15'(b);
         exp_data = 16'h1000 + 16'(b);
         check_eq("err_dma_en", bus.dma_en, 1);
         check_eq("err_dma_addr", bus.dma_addr, exp_addr);
         step();
         bus.dma_resp = (b == 2);
         bus.dma_dout = exp_data;
         step();
         bus.dma_resp = 1'b0;
         bus.dma_dout = 16'h0000;
         check_eq("err_rsp_data", bus.rsp_data, exp_data);
         check_eq("err_rsp_err", bus.rsp_err, (b == 2) ? 1 : 0);
         check_eq("err_rsp_last", bus.rsp_last, (b == 2) ? 1 : 0);
         step();
      end
      check_eq("err_back_idle", bus.cmd_ready, 1);
      bad = 0;
      repeat (5) begin
         if (bus.dma_en !== 1'b0 || bus.rsp_valid !== 1'b0) bad++;
         step();
      end
      check_eq("err_no_more_beats", bad, 0);
      bus.dma_ready = 1'b0;
      bus.rsp_ready = 1'b0;

      // Response backpressure, then reset during the next request
      send_cmd(15'h0300, 16'h0000, 2'b00, 8'd1, 1'b0);
      bus.dma_ready = 1'b1;
      step();
      bus.dma_ready = 1'b0;
      bus.dma_dout  = 16'h5A5A;
      step();
      bus.dma_dout  = 16'h0000;
      check_eq("bp_rsp_valid", bus.rsp_valid, 1);
      check_eq("bp_rsp_data", bus.rsp_data, 16'h5A5A);
      check_eq("bp_rsp_last", bus.rsp_last, 0);
      bad = 0;
      repeat (10) begin
         step();
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h5A5A || bus.rsp_last !== 1'b0 ||
             bus.rsp_err !== 1'b0 || bus.dma_en !== 1'b0)
            bad++;
      end
      check_eq("bp_stable", bad, 0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check_eq("bp_next_dma_en", bus.dma_en, 1);
      check_eq("bp_next_dma_addr", bus.dma_addr, 15'h0301);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check_eq("mid_rst_dma_en", bus.dma_en, 0);
      check_eq("mid_rst_trace", bus.trace, 0);
      check_eq("mid_rst_cmd_ready", bus.cmd_ready, 1);
      check_eq("mid_rst_rsp_valid", bus.rsp_valid, 0);
      bad = 0;
      repeat (4) begin
         step();
         if (bus.rsp_valid !== 1'b0 || bus.dma_en !== 1'b0) bad++;
      end
      check_eq("mid_rst_no_rsp", bad, 0);

      // dma_ready trace, oldest sample first
      pat = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         bus.dma_ready = pat[3 - i];
         step();
      end
      bus.dma_ready = 1'b0;
      check_eq("trace_pattern", bus.trace, 16'h000B);
      step();
      check_eq("trace_shift", bus.trace, 16'h0016);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
